// File: rtl/dist_com_fifo_rd_if.sv
// Read-side adapter for the distributed common FIFOs: drains a one-cycle-latency
// FIFO read port into a small prefetch buffer and presents it as a valid/ready stream.
module dist_com_fifo_rd_if #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 3
) (
  input  logic             I_fifo_clk,
  input  logic             I_fifo_rst_n,
  output logic             O_fifo_rd,
  input  logic [WIDTH-1:0] I_fifo_dout,
  input  logic             I_fifo_empty,
  input  logic             I_flush,
  output logic             O_out_valid,
  input  logic             I_out_ready,
  output logic [WIDTH-1:0] O_out_data,
  output logic [1:0]       O_level,
  output logic [15:0]      O_word_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    cnt;
  logic             inflight;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] buf_mem [DEPTH];
  logic [15:0]      word_cnt;
  logic [CW:0]      occupied;
  logic             capture;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reserve a slot for every word already requested, so the read strobe depends
  // on registered state only and the buffer can never overflow.
  assign occupied  = {1'b0, cnt} + (CW + 1)'(inflight);
  assign O_fifo_rd = I_fifo_rst_n && !I_fifo_empty && !I_flush
                     && (occupied < (CW + 1)'(DEPTH));

  // Stream handshake: a word transfers on every cycle where O_out_valid and
  // I_out_ready are both high; O_out_data holds steady while valid waits on ready.
  assign O_out_valid = (cnt != '0);
  assign O_out_data  = buf_mem[rptr];
  assign O_level     = 2'(cnt);
  assign O_word_cnt  = word_cnt;

  // A flush discards both the buffered words and the word returning this cycle.
  assign capture = inflight && !I_flush;
  assign pop     = O_out_valid && I_out_ready && !I_flush;

  always_ff @(posedge I_fifo_clk or negedge I_fifo_rst_n) begin
    if (!I_fifo_rst_n) begin
      cnt      <= '0;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      word_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      inflight <= O_fifo_rd;
      if (pop) begin
        word_cnt <= word_cnt + 16'd1;
      end
      if (I_flush) begin
        cnt  <= '0;
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (capture) begin
          buf_mem[wptr] <= I_fifo_dout;
          wptr          <= ptr_inc(wptr);
        end
        if (pop) begin
          rptr <= ptr_inc(rptr);
        end
        case ({capture, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dist_com_fifo_rd_if.sv
// Bench for dist_com_fifo_rd_if: a queue-based FIFO model feeds the read port and
// a scoreboard queue holds every word still owed to the consumer, in order.
module tb_dist_com_fifo_rd_if;

  localparam int WIDTH = 28;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             O_fifo_rd;
  logic [WIDTH-1:0] I_fifo_dout;
  logic             I_fifo_empty;
  logic             I_flush;
  logic             O_out_valid;
  logic             I_out_ready;
  logic [WIDTH-1:0] O_out_data;
  logic [1:0]       O_level;
  logic [15:0]      O_word_cnt;

  always #5 clk = ~clk;

  dist_com_fifo_rd_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .I_fifo_clk  (clk),
    .I_fifo_rst_n(rst_n),
    .O_fifo_rd   (O_fifo_rd),
    .I_fifo_dout (I_fifo_dout),
    .I_fifo_empty(I_fifo_empty),
    .I_flush     (I_flush),
    .O_out_valid (O_out_valid),
    .I_out_ready (I_out_ready),
    .O_out_data  (O_out_data),
    .O_level     (O_level),
    .O_word_cnt  (O_word_cnt)
  );

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] next_dout;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;

  int               m_cnt;
  bit               m_infl;
  logic [15:0]      m_wc;
  int               total_dlv;

  bit               prev_valid, prev_ready, prev_fl, prev_rd;
  logic [WIDTH-1:0] prev_data;

  bit               s_rd, s_valid, s_pop;
  logic [1:0]       s_level;
  logic [15:0]      s_wc;
  logic [WIDTH-1:0] s_pop_data;

  task automatic push_word(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic drop_words(input int n);
    logic [WIDTH-1:0] tmp;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() > 0) tmp = exp_q.pop_front();
    end
  endtask

  task automatic reset_model();
    drop_words(m_cnt + int'(m_infl));
    m_cnt      = 0;
    m_infl     = 1'b0;
    m_wc       = '0;
    total_dlv  = 0;
    prev_valid = 1'b0;
    prev_rd    = 1'b0;
  endtask

  // One clock: drive inputs just after the edge, sample and score at the negedge.
  task automatic cycle(input bit rdy, input bit fl);
    bit               model_rd;
    bit               pop;
    logic [WIDTH-1:0] exp_w;
    I_out_ready  = rdy;
    I_flush      = fl;
    I_fifo_empty = (fifo_q.size() == 0);
    I_fifo_dout  = next_dout;
    @(negedge clk);
    cyc++;
    model_rd = !I_fifo_empty && !fl && (m_cnt + int'(m_infl) < DEPTH);
    s_rd     = O_fifo_rd;
    s_valid  = O_out_valid;
    s_level  = O_level;
    s_wc     = O_word_cnt;
    s_pop    = 1'b0;
    checks++;
    if (O_fifo_rd !== model_rd) begin
      errors++;
      $display("FAIL rd_strobe cycle %0d: got %b expected %b", cyc, O_fifo_rd, model_rd);
    end
    checks++;
    if (O_out_valid !== (m_cnt != 0)) begin
      errors++;
      $display("FAIL out_valid cycle %0d: got %b expected %b", cyc, O_out_valid, (m_cnt != 0));
    end
    checks++;
    if (O_level !== 2'(m_cnt)) begin
      errors++;
      $display("FAIL level cycle %0d: got %0d expected %0d", cyc, O_level, m_cnt);
    end
    checks++;
    if (O_word_cnt !== m_wc) begin
      errors++;
      $display("FAIL word_cnt cycle %0d: got %0d expected %0d", cyc, O_word_cnt, m_wc);
    end
    checks++;
    if (int'(O_level) + int'(prev_rd) > DEPTH) begin
      errors++;
      $display("FAIL occupancy cycle %0d: level %0d + inflight %0d exceeds %0d",
               cyc, O_level, prev_rd, DEPTH);
    end
    if (prev_valid && !prev_ready && !prev_fl && O_out_valid) begin
      checks++;
      if (O_out_data !== prev_data) begin
        errors++;
        $display("FAIL data_hold cycle %0d: got %h expected %h", cyc, O_out_data, prev_data);
      end
    end
    if (O_fifo_rd) begin
      checks++;
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL underflow cycle %0d: read issued with %0d words in FIFO", cyc, fifo_q.size());
      end else begin
        next_dout = fifo_q.pop_front();
      end
    end
    pop = rdy && !fl && (m_cnt != 0);
    if (pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard cycle %0d: got %h expected no word", cyc, O_out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (O_out_data !== exp_w) begin
          errors++;
          $display("FAIL out_data cycle %0d: got %h expected %h", cyc, O_out_data, exp_w);
        end
      end
      s_pop      = 1'b1;
      s_pop_data = O_out_data;
      m_wc       = m_wc + 16'd1;
      total_dlv++;
    end
    if (fl) begin
      drop_words(m_cnt + int'(m_infl));
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + int'(m_infl) - int'(pop);
    end
    m_infl     = model_rd;
    prev_valid = O_out_valid;
    prev_ready = rdy;
    prev_fl    = fl;
    prev_data  = O_out_data;
    prev_rd    = O_fifo_rd;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d words left expected 0 within %0d cycles", name, exp_q.size(), budget);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({O_fifo_rd, O_out_valid, O_out_data, O_level, O_word_cnt} !== '0) begin
      errors++;
      $display("FAIL %s: got rd=%b valid=%b data=%h level=%0d wc=%0d expected all 0",
               name, O_fifo_rd, O_out_valid, O_out_data, O_level, O_word_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    I_flush      = 1'b0;
    I_out_ready  = 1'b0;
    I_fifo_empty = 1'b1;
    I_fifo_dout  = '0;
    next_dout    = '0;
    m_cnt = 0; m_infl = 1'b0; m_wc = '0; total_dlv = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_fl = 1'b0; prev_rd = 1'b0; prev_data = '0;
    #2;
    check_outputs_zero("por_outputs");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_burst();
    int first_rd = -1, last_rd = -1, first_valid = -1, n_rd = 0;
    for (int i = 1; i <= 5; i++) push_word(WIDTH'(i));
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0);
      if (s_rd) begin
        if (first_rd < 0) first_rd = i;
        last_rd = i;
        n_rd++;
      end
      if (s_valid && first_valid < 0) first_valid = i;
    end
    checks++;
    if (n_rd != 5 || last_rd - first_rd != 4) begin
      errors++;
      $display("FAIL burst_reads: got %0d reads over span %0d expected 5 over span 4", n_rd, last_rd - first_rd);
    end
    checks++;
    if (first_valid - first_rd != 2) begin
      errors++;
      $display("FAIL burst_latency: got %0d expected 2", first_valid - first_rd);
    end
    checks++;
    if (s_wc !== 16'd5 || s_level !== 2'd0) begin
      errors++;
      $display("FAIL burst_end: got wc=%0d level=%0d expected wc=5 level=0", s_wc, s_level);
    end
  endtask

  task automatic test_backpressure();
    int n_rd = 0;
    for (int i = 0; i < 10; i++) push_word(WIDTH'(28'h0A00000 + i));
    repeat (8) begin
      cycle(1'b0, 1'b0);
      if (s_rd) n_rd++;
    end
    checks++;
    if (n_rd != 3 || s_level !== 2'd3 || s_rd) begin
      errors++;
      $display("FAIL bp_stall: got reads=%0d level=%0d rd=%b expected reads=3 level=3 rd=0", n_rd, s_level, s_rd);
    end
    drain("bp", 40);
    checks++;
    if (fifo_q.size() != 0) begin
      errors++;
      $display("FAIL bp_usedw: got %0d expected 0", fifo_q.size());
    end
  endtask

  task automatic test_flush();
    int n = 0;
    logic [15:0] wc_before;
    for (int i = 0; i < 6; i++) push_word(WIDTH'(28'h0000F00 + i));
    while (!(m_cnt == 2 && m_infl) && n < 10) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    wc_before = m_wc;
    cycle(1'b0, 1'b1);
    checks++;
    if (s_level !== 2'd2) begin
      errors++;
      $display("FAIL flush_setup: got level %0d expected 2", s_level);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (s_level !== 2'd0 || s_valid || s_wc !== wc_before) begin
      errors++;
      $display("FAIL flush_clear: got level=%0d valid=%b wc=%0d expected level=0 valid=0 wc=%0d",
               s_level, s_valid, s_wc, wc_before);
    end
    n = 0;
    s_pop = 1'b0;
    while (!s_pop && n < 10) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    checks++;
    if (!s_pop || s_pop_data !== 28'h0000F03) begin
      errors++;
      $display("FAIL flush_next_word: got %h (popped=%b) expected 0000f03", s_pop_data, s_pop);
    end
    drain("flush", 20);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 6; i++) push_word(WIDTH'(28'h0000100 + i));
    repeat (3) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset_outputs");
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (O_fifo_rd !== 1'b0) begin
        errors++;
        $display("FAIL midreset_rd: got %b expected 0 (FIFO holds %0d)", O_fifo_rd, fifo_q.size());
      end
    end
    @(posedge clk);
    #1;
    reset_model();
    rst_n = 1'b1;
    drain("midreset", 30);
  endtask

  task automatic test_soak();
    int written = 0, n = 0, start = total_dlv;
    while ((written < 10000 || exp_q.size() > 0) && n < 40000) begin
      if (written < 10000 && $urandom_range(0, 9) < 6) begin
        push_word(WIDTH'($urandom));
        written++;
      end
      cycle($urandom_range(0, 4) != 0, 1'b0);
      n++;
    end
    checks++;
    if (total_dlv - start != 10000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL soak_count: got %0d delivered expected 10000", total_dlv - start);
    end
  endtask

  task automatic test_wrap();
    int need = 65537 - total_dlv - exp_q.size();
    int written = 0, n = 0;
    while (total_dlv < 65537 && n < 70000) begin
      if (written < need && fifo_q.size() < 4) begin
        push_word(WIDTH'($urandom));
        written++;
      end
      cycle(1'b1, 1'b0);
      n++;
    end
    cycle(1'b1, 1'b0);
    checks++;
    if (total_dlv != 65537 || s_wc !== 16'd1) begin
      errors++;
      $display("FAIL wrap: got delivered=%0d wc=%0d expected delivered=65537 wc=1", total_dlv, s_wc);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_soak();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
